tl_phase_sched: RTL and testbench

//  Timed two-road traffic-light phase scheduler. Shares one intersection between road A and road B

---
 rtl/tl_phase_sched_if.sv | 19 +
 rtl/tl_phase_sched.sv | 129 ++++++++++++
 tb/tb_tl_phase_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_phase_sched_if.sv
// Sensor inputs and lamp outputs of the two-road phase scheduler.
// The walk-request signals exist only when TL_PED_EN is defined.
interface tl_phase_sched_if;
    logic       Ta;
    logic       Tb;
    logic [1:0] La;
    logic [1:0] Lb;
    logic [2:0] phase;
`ifdef TL_PED_EN
    logic       ped_req;
    logic       ped_walk;

    modport master (output Ta, Tb, ped_req, input La, Lb, phase, ped_walk);
    modport slave  (input Ta, Tb, ped_req, output La, Lb, phase, ped_walk);
`else
    modport master (output Ta, Tb, input La, Lb, phase);
    modport slave  (input Ta, Tb, output La, Lb, phase);
`endif
endinterface

// File: rtl/tl_phase_sched.sv
// Two-road traffic-light phase scheduler: one Moore FSM plus a saturating dwell timer.
// Optional pedestrian walk phase is built when TL_PED_EN is defined.
//
//  state | meaning
//  AG    | road A green, road B red
//  AY    | road A yellow, road B red
//  AR    | both red, clearing towards B (walk phase when requested)
//  BG    | road B green, road A red
//  BY    | road B yellow, road A red
//  BR    | both red, clearing towards A (walk phase when requested)
module tl_phase_sched #(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int PED_T     = 6
) (
    input logic             clk,
    input logic             reset,
    tl_phase_sched_if.slave bus
);

    typedef enum logic [2:0] {
        AG = 3'd0,
        AY = 3'd1,
        AR = 3'd2,
        BG = 3'd3,
        BY = 3'd4,
        BR = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_T - 1);

    if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_T < 1 || ALLRED_T < 1 ||
        PED_T < ALLRED_T || CNT_W < 1 || CNT_W > 31 ||
        (1 << CNT_W) <= GREEN_MAX || (1 << CNT_W) <= PED_T) begin : g_bad_param
        $error("tl_phase_sched: illegal parameter set");
    end

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] tmr;
    logic             want_b;
    logic             want_a;
    logic [CNT_W-1:0] red_last;
    logic [1:0]       la;
    logic [1:0]       lb;

`ifdef TL_PED_EN
    logic ped_pend;
    logic walk;
    logic enter_red;

    // Pending walk request behaves like opposing demand on either green.
    assign want_b    = (!bus.Ta && bus.Tb) || ped_pend;
    assign want_a    = (!bus.Tb && bus.Ta) || ped_pend;
    assign red_last  = walk ? PED_LAST : RED_LAST;
    assign enter_red = (state == AY && state_nx == AR) || (state == BY && state_nx == BR);

    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else if (enter_red) begin
            walk     <= ped_pend;
            ped_pend <= bus.ped_req;
        end else begin
            if (bus.ped_req)
                ped_pend <= 1'b1;
            if (state_nx != state)
                walk <= 1'b0;
        end
    end

    assign bus.ped_walk = walk && (state == AR || state == BR);
`else
    assign want_b   = !bus.Ta && bus.Tb;
    assign want_a   = !bus.Tb && bus.Ta;
    assign red_last = RED_LAST;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AG;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                tmr <= '0;
            else if (tmr != '1)
                tmr <= tmr + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            AG: if ((tmr >= MIN_LAST && want_b) || (tmr >= MAX_LAST && bus.Tb)) state_nx = AY;
            AY: if (tmr == YEL_LAST) state_nx = AR;
            AR: if (tmr == red_last) state_nx = BG;
            BG: if ((tmr >= MIN_LAST && want_a) || (tmr >= MAX_LAST && bus.Ta)) state_nx = BY;
            BY: if (tmr == YEL_LAST) state_nx = BR;
            BR: if (tmr == red_last) state_nx = AG;
            default: state_nx = AG;
        endcase
    end

    always_comb begin
        la = 2'b10;
        lb = 2'b10;
        case (state)
            AG: la = 2'b00;
            AY: la = 2'b01;
            BG: lb = 2'b00;
            BY: lb = 2'b01;
            default: ;
        endcase
    end

    assign bus.La    = la;
    assign bus.Lb    = lb;
    assign bus.phase = state;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Scoreboard bench for tl_phase_sched: per-cycle stimulus and expected phase queued together.
module tb_tl_phase_sched;

    localparam logic [2:0] PH_AG = 3'd0;
    localparam logic [2:0] PH_AY = 3'd1;
    localparam logic [2:0] PH_AR = 3'd2;
    localparam logic [2:0] PH_BG = 3'd3;
    localparam logic [2:0] PH_BY = 3'd4;
    localparam logic [2:0] PH_BR = 3'd5;

    typedef struct packed {
        logic       rst;
        logic       ta;
        logic       tb;
        logic       pr;
        logic [2:0] ph;
        logic       walk;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    logic walk_obs;
    int   total = 0;
    int   bad = 0;
    int   cyc;
    step_t q[$];
    step_t e;
    logic [7:0] obs;
    logic [7:0] expv;

    tl_phase_sched_if bus ();

    tl_phase_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef TL_PED_EN
    assign walk_obs = bus.ped_walk;
`else
    assign walk_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [1:0] la_of(input logic [2:0] ph);
        case (ph)
            PH_AG:   return 2'b00;
            PH_AY:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] lb_of(input logic [2:0] ph);
        case (ph)
            PH_BG:   return 2'b00;
            PH_BY:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic push_seg(input logic rst, input logic ta, input logic tb, input logic pr,
                            input logic [2:0] ph, input logic walk, input int n);
        for (int i = 0; i < n; i++) q.push_back('{rst, ta, tb, pr, ph, walk});
    endtask

    task automatic drive(input step_t s);
        reset  = s.rst;
        bus.Ta = s.ta;
        bus.Tb = s.tb;
`ifdef TL_PED_EN
        bus.ped_req = s.pr;
`endif
    endtask

    // Two reset cycles; returns at the falling edge that starts cycle 0.
    task automatic apply_reset();
        drive('{1'b1, 1'b0, 1'b0, 1'b0, PH_AG, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        push_seg(0, 0, 0, 0, PH_AG, 0, 30);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive(e);
            obs  = {bus.La, bus.Lb, bus.phase, walk_obs};
            expv = {la_of(e.ph), lb_of(e.ph), e.ph, e.walk};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_gap_out();
        apply_reset();
        push_seg(0, 0, 1, 0, PH_AG, 0, 4);
        push_seg(0, 0, 1, 0, PH_AY, 0, 3);
        push_seg(0, 0, 1, 0, PH_AR, 0, 2);
        push_seg(0, 0, 1, 0, PH_BG, 0, 6);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive(e);
            obs  = {bus.La, bus.Lb, bus.phase, walk_obs};
            expv = {la_of(e.ph), lb_of(e.ph), e.ph, e.walk};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL gap_out cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            push_seg(0, 1, 1, 0, PH_AG, 0, 12);
            push_seg(0, 1, 1, 0, PH_AY, 0, 3);
            push_seg(0, 1, 1, 0, PH_AR, 0, 2);
            push_seg(0, 1, 1, 0, PH_BG, 0, 12);
            push_seg(0, 1, 1, 0, PH_BY, 0, 3);
            push_seg(0, 1, 1, 0, PH_BR, 0, 2);
        end
        push_seg(0, 1, 1, 0, PH_AG, 0, 2);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive(e);
            obs  = {bus.La, bus.Lb, bus.phase, walk_obs};
            expv = {la_of(e.ph), lb_of(e.ph), e.ph, e.walk};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL max_out cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_demand_drop();
        apply_reset();
        for (int c = 0; c < 12; c++)
            push_seg(0, 0, (c < 2 || c >= 9), 0, (c <= 9) ? PH_AG : PH_AY, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive(e);
            obs  = {bus.La, bus.Lb, bus.phase, walk_obs};
            expv = {la_of(e.ph), lb_of(e.ph), e.ph, e.walk};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL demand_drop cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_yellow();
        apply_reset();
        push_seg(0, 0, 1, 0, PH_AG, 0, 4);
        push_seg(0, 0, 1, 0, PH_AY, 0, 3);
        push_seg(0, 0, 1, 0, PH_AR, 0, 2);
        push_seg(0, 1, 0, 0, PH_BG, 0, 4);
        push_seg(0, 1, 0, 0, PH_BY, 0, 1);
        push_seg(1, 1, 0, 0, PH_BY, 0, 1);
        push_seg(0, 0, 1, 0, PH_AG, 0, 4);
        push_seg(0, 0, 1, 0, PH_AY, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive(e);
            obs  = {bus.La, bus.Lb, bus.phase, walk_obs};
            expv = {la_of(e.ph), lb_of(e.ph), e.ph, e.walk};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset_in_by cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

`ifdef TL_PED_EN
    task automatic test_ped_walk();
        apply_reset();
        push_seg(0, 1, 0, 0, PH_AG, 0, 1);
        push_seg(0, 1, 0, 1, PH_AG, 0, 1);
        push_seg(0, 1, 0, 0, PH_AG, 0, 2);
        push_seg(0, 1, 0, 0, PH_AY, 0, 3);
        push_seg(0, 1, 0, 0, PH_AR, 1, 6);
        push_seg(0, 1, 0, 0, PH_BG, 0, 2);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive(e);
            obs  = {bus.La, bus.Lb, bus.phase, walk_obs};
            expv = {la_of(e.ph), lb_of(e.ph), e.ph, e.walk};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL ped_walk cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        bus.Ta = 1'b0;
        bus.Tb = 1'b0;
`ifdef TL_PED_EN
        bus.ped_req = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_gap_out();
        test_back_to_back();
        test_demand_drop();
        test_reset_in_yellow();
`ifdef TL_PED_EN
        test_ped_walk();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
